// File: rtl/aidan_mcnay_iter_divider.sv
// -----------------------------------------------------------------------------
// aidan_mcnay_iter_divider
//
// Iterative restoring unsigned divider. It accepts one {dividend, divisor}
// request on a val/rdy input stream and resolves one quotient bit per clock,
// nbits cycles in all. It then holds {quotient, remainder} on a val/rdy output
// stream until the consumer takes it. Division by zero is not special-cased.
// The restoring algorithm naturally returns quotient = all ones and
// remainder = dividend in that case.
//
// Ports:
//   clk                - clock, all state updates on the rising edge
//   reset              - asynchronous active-high reset
//   istream_val        - request valid
//   istream_rdy        - divider idle and able to accept a request
//   istream_dividend   - unsigned dividend  (nbits)
//   istream_divisor    - unsigned divisor   (nbits)
//   ostream_val        - result valid (held until consumed)
//   ostream_rdy        - consumer can take the result
//   ostream_quotient   - unsigned quotient  (nbits)
//   ostream_remainder  - unsigned remainder (nbits)
// -----------------------------------------------------------------------------
module aidan_mcnay_iter_divider #(
    parameter int nbits = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [nbits-1:0] istream_dividend,
    input  logic [nbits-1:0] istream_divisor,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [nbits-1:0] ostream_quotient,
    output logic [nbits-1:0] ostream_remainder
);

    localparam int CNT_W = $clog2(nbits);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [nbits-1:0]   q;        // dividend shifts out the top, quotient bits shift in the bottom
    logic [nbits-1:0]   rem;      // partial remainder
    logic [nbits-1:0]   divisor;
    logic [CNT_W-1:0]   cnt;

    logic [nbits:0]     shifted;
    logic [nbits:0]     trial;

    // The restored partial remainder is always strictly less than the divisor,
    // so it fits in nbits bits. Only the trial subtraction needs the extra bit:
    // its MSB is the borrow that decides the quotient bit.
    always_comb begin
        shifted = {rem, q[nbits-1]};
        trial   = shifted - {1'b0, divisor};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            q       <= '0;
            rem     <= '0;
            divisor <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (istream_val && istream_rdy) begin
                        divisor <= istream_divisor;
                        q       <= istream_dividend;
                        rem     <= '0;
                        cnt     <= CNT_W'(nbits - 1);
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (!trial[nbits]) begin
                        rem <= trial[nbits-1:0];
                        q   <= {q[nbits-2:0], 1'b1};
                    end else begin
                        rem <= shifted[nbits-1:0];
                        q   <= {q[nbits-2:0], 1'b0};
                    end
                    cnt <= cnt - CNT_W'(1);
                    // The step taken with cnt == 0 is the last of nbits steps.
                    if (cnt == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (ostream_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ready is gated by reset so that it drops immediately on an asynchronous
    // reset, including while the divider is already idle.
    assign istream_rdy       = (state == IDLE) && !reset;
    assign ostream_val       = (state == DONE);
    assign ostream_quotient  = q;
    assign ostream_remainder = rem;

endmodule

// File: tb/tb_aidan_mcnay_iter_divider.sv
// -----------------------------------------------------------------------------
// Testbench for aidan_mcnay_iter_divider (nbits = 16). The stimulus pushes
// the hand-computed expected {quotient, remainder} into a queue when each
// request is accepted. A monitor pops the queue and compares every transfer
// on the output stream.
// -----------------------------------------------------------------------------
module tb_aidan_mcnay_iter_divider;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         istream_val = 1'b0;
    logic         istream_rdy;
    logic [N-1:0] istream_dividend = '0;
    logic [N-1:0] istream_divisor = '0;
    logic         ostream_val;
    logic         ostream_rdy = 1'b1;
    logic [N-1:0] ostream_quotient;
    logic [N-1:0] ostream_remainder;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_q[$];
    bit rand_rdy = 0;

    aidan_mcnay_iter_divider #(.nbits(N)) dut (
        .clk               (clk),
        .reset             (reset),
        .istream_val       (istream_val),
        .istream_rdy       (istream_rdy),
        .istream_dividend  (istream_dividend),
        .istream_divisor   (istream_divisor),
        .ostream_val       (ostream_val),
        .ostream_rdy       (ostream_rdy),
        .ostream_quotient  (ostream_quotient),
        .ostream_remainder (ostream_remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    endtask

    // Monitor: the output transfer happens at the next posedge when val & rdy
    // are both high at the preceding negedge.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!reset && ostream_val && ostream_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {ostream_quotient, ostream_remainder}, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient", 32'(ostream_quotient), 32'(e[31:16]));
                    chk("remainder", 32'(ostream_remainder), 32'(e[15:0]));
                end
            end
        end
    end

    // Random consumer backpressure, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) ostream_rdy = 1'($urandom_range(0, 1));
        end
    end

    // Must be entered just after a rising edge. Returns just after the
    // accepting edge; istream_val is left high.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] eq, input logic [N-1:0] er, input bit push);
        int n = 0;
        istream_val = 1'b1;
        istream_dividend = a;
        istream_divisor = b;
        @(negedge clk);
        while (!istream_rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!istream_rdy) begin
            chk("accept_timeout", 32'(n), 32'd0);
        end else begin
            if (push) exp_q.push_back({eq, er});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct { logic [N-1:0] a, b, q, r; } vec_t;

    initial begin
        vec_t dir[5];
        vec_t b2b[10];
        int n;

        dir[0] = '{16'd97,   16'd13,   16'd7,    16'd6};
        dir[1] = '{16'd5,    16'd9,    16'd0,    16'd5};
        dir[2] = '{16'hFFFF, 16'd1,    16'hFFFF, 16'd0};
        dir[3] = '{16'hFFFF, 16'hFFFF, 16'd1,    16'd0};
        dir[4] = '{16'h1234, 16'd0,    16'hFFFF, 16'h1234};

        b2b[0] = '{16'd1000,  16'd7,     16'd142,   16'd6};
        b2b[1] = '{16'd65535, 16'd256,   16'd255,   16'd255};
        b2b[2] = '{16'd12345, 16'd123,   16'd100,   16'd45};
        b2b[3] = '{16'd500,   16'd500,   16'd1,     16'd0};
        b2b[4] = '{16'd3,     16'd65535, 16'd0,     16'd3};
        b2b[5] = '{16'd40000, 16'd3,     16'd13333, 16'd1};
        b2b[6] = '{16'd1,     16'd1,     16'd1,     16'd0};
        b2b[7] = '{16'd0,     16'd5,     16'd0,     16'd0};
        b2b[8] = '{16'd60000, 16'd250,   16'd240,   16'd0};
        b2b[9] = '{16'd777,   16'd0,     16'd65535, 16'd777};

        // Reset state
        #3;
        chk("reset_istream_rdy", 32'(istream_rdy), 32'd0);
        chk("reset_ostream_val", 32'(ostream_val), 32'd0);
        chk("reset_quotient", 32'(ostream_quotient), 32'd0);
        chk("reset_remainder", 32'(ostream_remainder), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_istream_rdy", 32'(istream_rdy), 32'd1);

        // 91/7 with latency checks
        send(16'd91, 16'd7, 16'd13, 16'd0, 1'b1);
        istream_val = 1'b0;
        chk("rdy_low_after_accept", 32'(istream_rdy), 32'd0);
        chk("val_low_after_accept", 32'(ostream_val), 32'd0);
        repeat (15) @(posedge clk);
        #1;
        chk("val_low_at_e15", 32'(ostream_val), 32'd0);
        @(posedge clk); #1;
        chk("val_high_at_e16", 32'(ostream_val), 32'd1);
        chk("rdy_low_in_done", 32'(istream_rdy), 32'd0);
        @(posedge clk); #1;
        chk("rdy_back_after_consume", 32'(istream_rdy), 32'd1);
        chk("val_low_after_consume", 32'(ostream_val), 32'd0);
        wait_drain("drain_91_7");

        // Directed non-clean and edge operands
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) send(dir[i].a, dir[i].b, dir[i].q, dir[i].r, 1'b1);
        istream_val = 1'b0;
        wait_drain("drain_directed");

        // Backpressure: 100/10 held for 5 cycles
        @(posedge clk); #1;
        ostream_rdy = 1'b0;
        send(16'd100, 16'd10, 16'd10, 16'd0, 1'b1);
        istream_val = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ostream_val && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_val_rises", 32'(ostream_val), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_val_held", 32'(ostream_val), 32'd1);
            chk("bp_q_held", 32'(ostream_quotient), 32'd10);
            chk("bp_r_held", 32'(ostream_remainder), 32'd0);
            chk("bp_rdy_low", 32'(istream_rdy), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        ostream_rdy = 1'b1;
        @(posedge clk); #1;
        chk("bp_val_low_after", 32'(ostream_val), 32'd0);
        chk("bp_idle_after", 32'(istream_rdy), 32'd1);
        wait_drain("drain_bp");

        // Reset mid-CALC: no result may appear for the abandoned request
        @(posedge clk); #1;
        send(16'd200, 16'd3, 16'd0, 16'd0, 1'b0);
        istream_val = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midreset_istream_rdy", 32'(istream_rdy), 32'd0);
        chk("midreset_ostream_val", 32'(ostream_val), 32'd0);
        chk("midreset_quotient", 32'(ostream_quotient), 32'd0);
        chk("midreset_remainder", 32'(ostream_remainder), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ostream_val) n++;
        end
        chk("midreset_no_result", 32'(n), 32'd0);
        @(posedge clk); #1;
        send(16'd200, 16'd3, 16'd66, 16'd2, 1'b1);
        istream_val = 1'b0;
        wait_drain("drain_after_reset");

        // Back-to-back stream with random consumer readiness
        @(posedge clk); #1;
        rand_rdy = 1;
        for (int i = 0; i < 10; i++) send(b2b[i].a, b2b[i].b, b2b[i].q, b2b[i].r, 1'b1);
        istream_val = 1'b0;
        wait_drain("drain_stream");
        rand_rdy = 0;
        @(posedge clk); #2;
        ostream_rdy = 1'b1;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1, "timeout");
    end

endmodule
